// File: rtl/bram_snapshot_pkg.sv
// Shared constants for the BRAM snapshot capture block.
// State encoding, default widths and small state helpers.
package bram_snapshot_pkg;

    localparam int DIN_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DECIM_WIDTH    = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic logic st_busy(input logic [1:0] st);
        return (st == ST_ARMED) || (st == ST_CAPTURE);
    endfunction

    function automatic logic st_rearmable(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/bram_snapshot_edge_detect.sv
// Registered rising-edge detector for a level input.
// rise = d & ~d_q, with d_q cleared by reset.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/bram_snapshot.sv
// Triggered snapshot of a sample stream into a BRAM write port.
// Optional decimation is enabled with BRAM_SNAPSHOT_DECIM_EN.
module bram_snapshot
    import bram_snapshot_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                   fpga_clk,
    input  logic                   rst_n,
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic                   din_valid,
    input  logic                   arm,
    input  logic                   trigger,
`ifdef BRAM_SNAPSHOT_DECIM_EN
    input  logic [DECIM_WIDTH-1:0] decim,
`endif
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [DIN_WIDTH-1:0]   bram_din,
    output logic                   bram_we,
    output logic                   busy,
    output logic                   done
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  arm_rise;
    logic                  last;
    logic                  dec_hit;
    logic                  accept;
    logic                  rearm;
    logic                  start;

    edge_detect u_arm_edge (
        .clk   (fpga_clk),
        .rst_n (rst_n),
        .d     (arm),
        .rise  (arm_rise)
    );

    assign rearm = arm_rise && st_rearmable(state);
    assign start = (state == ST_ARMED) && trigger;
    assign last  = &cnt;

`ifdef BRAM_SNAPSHOT_DECIM_EN
    logic [DECIM_WIDTH-1:0] dcnt;

    // Counts valid samples in CAPTURE; the first of each group is kept.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (start) begin
            dcnt <= '0;
        end else if ((state == ST_CAPTURE) && din_valid) begin
            if (dcnt >= decim) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign dec_hit = (dcnt == '0);
`else
    assign dec_hit = 1'b1;
`endif

    assign accept = (state == ST_CAPTURE) && din_valid && dec_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm_rise) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (accept && last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (arm_rise) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter saturates at the top address so it can never wrap to 0.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rearm) begin
            cnt <= '0;
        end else if (accept && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= accept;
            if (accept) begin
                bram_addr <= cnt;
                bram_din  <= din;
            end
        end
    end

    assign busy = st_busy(state);
    assign done = (state == ST_DONE);

endmodule

// File: doc/bram_snapshot.md
BRAM_SNAPSHOT -- requirements
Module: bram_snapshot

Interface
REQ-001 Parameter DIN_WIDTH, default 32: sample width in bits; equals the BRAM write-port data width.
REQ-002 Parameter ADDR_WIDTH, default 10: BRAM write-port address width; capture depth is 2^ADDR_WIDTH samples.
REQ-003 fpga_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  DIN_WIDTH  sample data.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 arm  input  1  level from a software register; a rising edge arms the block.
REQ-008 trigger  input  1  level; starts capture while armed.
REQ-009 decim  input  8  decimation factor; present only with BRAM_SNAPSHOT_DECIM_EN.
REQ-010 bram_addr  output  ADDR_WIDTH  BRAM write address.
REQ-011 bram_din  output  DIN_WIDTH  BRAM write data.
REQ-012 bram_we  output  1  BRAM write enable.
REQ-013 busy  output  1  high in ARMED or CAPTURE.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARMED, CAPTURE and DONE.
REQ-016 arm SHALL be registered once; arm_rise = arm & ~arm_q.
REQ-017 An arm_rise in IDLE or DONE SHALL move the FSM to ARMED on the next cycle and SHALL clear done and the address counter.
REQ-018 An arm_rise in ARMED or CAPTURE SHALL be ignored.
REQ-019 trigger=1 in ARMED SHALL move the FSM to CAPTURE on the next cycle.
REQ-020 A din_valid in the same cycle as the trigger SHALL NOT be captured.
REQ-021 trigger SHALL be ignored in IDLE, CAPTURE and DONE.
REQ-022 In CAPTURE, each accepted sample SHALL produce exactly one write one cycle later: bram_we=1, bram_din=sample, bram_addr=counter value at acceptance.
REQ-023 The address counter SHALL increment by 1 per accepted sample.
REQ-024 Without decimation, an accepted sample is any cycle with din_valid=1.
REQ-025 bram_we SHALL be 0 in every cycle that does not follow an accepted sample.
REQ-026 All three BRAM outputs SHALL be registered.
REQ-027 The sample accepted at counter value 2^ADDR_WIDTH-1 SHALL be the last one; the FSM enters DONE on the next cycle.
REQ-028 That last write SHALL occur in the first DONE cycle.
REQ-029 The address counter SHALL never wrap; no write SHALL occur to address 0 after the last write.
REQ-030 DONE SHALL hold until the next arm_rise.
REQ-031 Throughput SHALL be one sample per cycle, with no stall cycles.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state=IDLE, counter=0, arm_q=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, and the decimation counter to 0.
REQ-033 Reset asserted mid-capture SHALL abort the capture; no further writes occur.
REQ-034 After reset release, the block SHALL stay in IDLE until an arm_rise.

Configuration
REQ-035 The macro BRAM_SNAPSHOT_DECIM_EN, when defined, SHALL add the decim port and an 8-bit decimation counter.
REQ-036 With the macro defined, only every (decim+1)-th din_valid in CAPTURE is accepted, starting with the first one.
REQ-037 With the macro defined, the decimation counter SHALL be cleared on entry to CAPTURE.
REQ-038 With the macro defined, decim=0 SHALL behave identically to the build without the macro.
REQ-039 With the macro undefined, the decim port and the decimation logic SHALL be absent, and every din_valid in CAPTURE is accepted.

Structure
REQ-040 State encoding (IDLE=0, ARMED=1, CAPTURE=2, DONE=3) SHALL live in the shared package bram_snapshot_pkg.
REQ-041 The default widths SHALL also live in bram_snapshot_pkg.
REQ-042 A sub-module edge_detect (registered rising-edge detector) SHALL be used for arm.
REQ-043 The outputs bram_din, bram_addr and bram_we SHALL connect directly to the fpga-side port of the AXI-Lite BRAM.
REQ-044 arm SHALL be driven from an AXI-Lite register, and busy/done SHALL be readable through one.

Verification (ADDR_WIDTH=4, DIN_WIDTH=32)
REQ-045 Reset, arm rise, trigger pulse, then din=0..15 with continuous din_valid:
- writes go to addr 0..15 with data 0..15;
- done=1 from the cycle of the addr-15 write;
- exactly 16 bram_we pulses.
REQ-046 din_valid toggling 1,0,1,0 during capture:
- writes occur only one cycle after valid cycles;
- addresses stay contiguous 0..15;
- no write occurs in gap cycles.
REQ-047 trigger held high before arm, then arm rise:
- capture starts one cycle after ARMED is reached;
- trigger pulses in IDLE and DONE cause no writes.
REQ-048 rst_n pulsed low after the addr-7 write:
- bram_we=0 immediately;
- state IDLE, done=0;
- a new arm/trigger cycle restarts at addr 0.
REQ-049 Second arm rise during CAPTURE:
- capture continues unaffected to addr 15.
- An arm rise in DONE clears done, returns to ARMED and restarts at addr 0 after the next trigger.
REQ-050 BRAM_SNAPSHOT_DECIM_EN defined, decim=3, continuous valid with din=0..63:
- captured data is 0,4,8,...,60 at addr 0..15.
